aes_iter_core: RTL and testbench

//   Iterative AES encryption core: one round per clock, parametrised key size (AES-128/192/256).

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_iter_core_if.sv | 15 +
 rtl/aes_round.sv | 29 ++
 rtl/aes_iter_core.sv | 147 ++++++++++++++
 tb/tb_aes_iter_core.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative cipher core.
// The S-box is a 2048-bit constant indexed by byte so each sbox() call maps to one ROM.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} aes_state_e;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset of entry b is 8*(255-b) = {~b, 3'b0}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_T[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < j; k++) r = xtime(r);
        return r;
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block-in / block-out valid-ready bus of the AES core; master is the host side.
interface aes_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [255:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (output in_valid, in_data, in_key, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_key, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         final_rnd,
    output logic [127:0] state_out
);
    logic [127:0] shr;
    logic [127:0] mc;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a [4];
        // Row r of column c comes from column (c+r)%4 of the input.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign a[r] = sbox(state_in[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        end
        assign shr[127 - 32*c -: 32] = {a[0], a[1], a[2], a[3]};
        assign mc[127 - 32*c -: 32] = {
            gmul2(a[0]) ^ gmul3(a[1]) ^ a[2] ^ a[3],
            a[0] ^ gmul2(a[1]) ^ gmul3(a[2]) ^ a[3],
            a[0] ^ a[1] ^ gmul2(a[2]) ^ gmul3(a[3]),
            gmul3(a[0]) ^ a[1] ^ a[2] ^ gmul2(a[3])
        };
    end

    assign state_out = (final_rnd ? shr : mc) ^ rk;
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor: key schedule built one word per clock, then one round per clock.
// Define AES_KEY_REUSE_EN to skip re-expansion when consecutive blocks use the same key.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_iter_core_if.slave  bus,
    output logic            busy
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);
    localparam int RW = 4;
    localparam int IW = RW + 2;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_e    st;
    logic [IW-1:0] widx;
    logic [2:0]    kpos;
    logic [7:0]    rcon_q;
    logic [RW-1:0] rnd;
    logic [127:0]  state_q;
    logic [31:0]   w [NW];

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Key expansion: kpos tracks i mod NK so no divider is needed; a single SubWord serves both cases.
    logic [31:0] prev, sw_in, sw, t, w_new;
    always_comb begin
        prev  = w[widx - IW'(1)];
        sw_in = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sw    = sub_word(sw_in);
        t     = prev;
        if (kpos == 3'd0)
            t = sw ^ {rcon_q, 24'h0};
        else if (NK == 8 && kpos == 3'd4)
            t = sw;
        w_new = w[widx - IW'(NK)] ^ t;
    end

    logic [IW-1:0] rk_base;
    logic [127:0]  rk, round_out;
    assign rk_base = {rnd, 2'b00};
    assign rk = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};

    aes_round u_round (
        .state_in  (state_q),
        .rk        (rk),
        .final_rnd (rnd == RW'(NR)),
        .state_out (round_out)
    );

    logic key_hit;
`ifdef AES_KEY_REUSE_EN
    logic sched_vld;
    // w[0..NK-1] always holds the key of the last accepted block.
    always_comb begin
        key_hit = sched_vld;
        for (int k = 0; k < NK; k++)
            if (w[k] != bus.in_key[255 - 32*k -: 32]) key_hit = 1'b0;
    end
`else
    assign key_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (st == IDLE && bus.in_valid) begin
            for (int k = 0; k < NK; k++) w[k] <= bus.in_key[255 - 32*k -: 32];
        end else if (st == EXPAND) begin
            w[widx] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
            rnd           <= '0;
            widx          <= IW'(NK);
            kpos          <= '0;
            rcon_q        <= rcon(1);
            state_q       <= '0;
`ifdef AES_KEY_REUSE_EN
            sched_vld     <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: if (bus.in_valid) begin
                    state_q      <= bus.in_data;
                    rnd          <= '0;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b1;
                    if (key_hit) begin
                        st <= ROUND;
                    end else begin
                        st     <= EXPAND;
                        widx   <= IW'(NK);
                        kpos   <= '0;
                        rcon_q <= rcon(1);
`ifdef AES_KEY_REUSE_EN
                        sched_vld <= 1'b0;
`endif
                    end
                end
                EXPAND: begin
                    widx <= widx + IW'(1);
                    kpos <= (kpos == 3'(NK - 1)) ? 3'd0 : kpos + 3'd1;
                    if (kpos == 3'd0) rcon_q <= xtime(rcon_q);
                    if (widx == IW'(NW - 1)) begin
                        st <= ROUND;
`ifdef AES_KEY_REUSE_EN
                        sched_vld <= 1'b1;
`endif
                    end
                end
                ROUND: begin
                    state_q <= (rnd == '0) ? state_q ^ rk : round_out;
                    if (rnd == RW'(NR)) begin
                        bus.out_data  <= round_out;
                        bus.out_valid <= 1'b1;
                        st            <= DONE;
                    end else begin
                        rnd <= rnd + RW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                    st            <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// Random-stimulus bench for aes_iter_core at all three key sizes against a byte-level AES model.
module tb_aes_iter_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic [127:0] in_data   [3];
    logic [255:0] in_key    [3];
    logic         out_ready [3];
    logic [2:0]   in_ready, out_valid, busy;
    logic [127:0] out_data  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_iter_core_if bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.in_data   = in_data[g];
        assign bus.in_key    = in_key[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_data[g]   = bus.out_data;
        aes_iter_core #(.KEY_BITS(128 + 64*g)) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy[g]));
    end

    int n_chk = 0;
    int n_err = 0;
    int lat_full  [3] = '{51, 59, 67};
    int lat_reuse [3] = '{11, 13, 15};
    logic         kv       [3];
    logic [255:0] last_key [3];
    logic [7:0]   sb_tab   [256];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int kb);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [240];
        logic [7:0] tw [4];
        logic [7:0] rc, x;
        logic [127:0] res;
        int nk, nr;
        nk = kb / 32;
        nr = nk + 6;
        for (int i = 0; i < 4*nk; i++) w[i] = key[255 - 8*i -: 8];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i - 1) + j];
            if (i % nk == 0) begin
                x = tw[0]; tw[0] = tw[1]; tw[1] = tw[2]; tw[2] = tw[3]; tw[3] = x;
                for (int j = 0; j < 4; j++) tw[j] = sb_tab[tw[j]];
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gf_mul(rc, 8'h02);
                tw[0] ^= rc;
            end else if (nk == 8 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) tw[j] = sb_tab[tw[j]];
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i - nk) + j] ^ tw[j];
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n];
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb_tab[s[4*((n/4 + n%4) % 4) + n%4]];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gf_mul(t[4*c], 2) ^ gf_mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 2) ^ gf_mul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 2) ^ gf_mul(t[4*c+3], 3);
                    s[4*c+3] = gf_mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c + j] = t[4*c + j];
                end
            end
            for (int n = 0; n < 16; n++) s[n] ^= w[16*r + n];
        end
        for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block through DUT k: accept, latency, result, optional backpressure, consume.
    task automatic run_block(input int k, input logic [127:0] d, input logic [255:0] key,
                             input logic [127:0] exp, input int hold, input string tag);
        int lat, wt, exp_lat;
        logic bad;
        logic [127:0] od;
        logic [255:0] used;
        used = key >> (256 - (128 + 64*k));
        exp_lat = lat_full[k];
`ifdef AES_KEY_REUSE_EN
        if (kv[k] && last_key[k] == used) exp_lat = lat_reuse[k];
`endif
        wt = 0;
        while (!in_ready[k] && wt < 10) begin @(posedge clk); #1; wt++; end
        chk({tag, "_in_ready"}, in_ready[k], 1);
        in_valid[k] = 1'b1; in_data[k] = d; in_key[k] = key;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid[k] && lat < 200) begin
            in_valid[k] = 1'($urandom); in_data[k] = rnd256()[127:0]; in_key[k] = rnd256();
            out_ready[k] = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        out_ready[k] = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_data"}, out_data[k], exp);
        chk({tag, "_busy"}, busy[k], 1);
        bad = 1'b0;
        od = out_data[k];
        repeat (hold) begin
            in_valid[k] = 1'($urandom); in_key[k] = rnd256();
            @(posedge clk); #1;
            if (out_valid[k] !== 1'b1 || out_data[k] !== od || in_ready[k] !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, bad, 0);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0; in_valid[k] = 1'b0;
        chk({tag, "_consumed"}, {in_ready[k], out_valid[k], busy[k]}, 3'b100);
        kv[k] = 1'b1;
        last_key[k] = used;
    endtask

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    logic [255:0] fkey [3];
    logic [127:0] fct  [3];

    initial begin
        logic [255:0] key, key2;
        logic [127:0] d;
        int k;
        fkey[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        fkey[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        fkey[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        fct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fct[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        fct[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_key[i] = '0; out_ready[i] = 1'b0;
            kv[i] = 1'b0; last_key[i] = '0;
        end
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_state", {in_ready[i], out_valid[i], busy[i], out_data[i]}, {3'b100, 128'h0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors; the 128-bit case carries garbage in the ignored key bits.
        run_block(0, PT, {fkey[0][255:128], rnd256()[127:0]}, fct[0], 0, "fips128");
        run_block(1, PT, fkey[1], fct[1], 0, "fips192");
        run_block(2, PT, fkey[2], fct[2], 0, "fips256");
        run_block(0, PT, fkey[0], fct[0], 20, "backpressure");

        // Same used key bits twice, then one flipped key bit.
        for (int i = 0; i < 3; i++) begin
            key = rnd256();
            d = rnd256()[127:0];
            run_block(i, d, key, aes_ref(d, key, 128 + 64*i), $urandom_range(0, 3), "same_key_a");
            key2 = key ^ (rnd256() >> (128 + 64*i));
            d = rnd256()[127:0];
            run_block(i, d, key2, aes_ref(d, key2, 128 + 64*i), $urandom_range(0, 3), "same_key_b");
            key2 = key ^ (256'h1 << (255 - $urandom_range(0, 127 + 64*i)));
            d = rnd256()[127:0];
            run_block(i, d, key2, aes_ref(d, key2, 128 + 64*i), 0, "new_key");
        end

        for (int n = 0; n < 6; n++) begin
            k = $urandom_range(0, 2);
            key = rnd256();
            d = rnd256()[127:0];
            run_block(k, d, key, aes_ref(d, key, 128 + 64*k), $urandom_range(0, 4), "random");
        end

        // Abort during round 5 of a full-expansion block.
        in_valid[0] = 1'b1; in_data[0] = PT; in_key[0] = rnd256();
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_reset_state", {in_ready[i], out_valid[i], busy[i], out_data[i]}, {3'b100, 128'h0});
            kv[i] = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, PT, fkey[0], fct[0], 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
